// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - TMDS mode type, fixed symbol codes and encoding helpers
package tmds_pkg;

    typedef enum logic [1:0] {
        MODE_CONTROL = 2'd0,
        MODE_VIDEO   = 2'd1,
        MODE_GUARD   = 2'd2,
        MODE_TERC4   = 2'd3
    } tmds_mode_t;

    localparam logic [9:0] CTRL_CODE_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_CODE_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_CODE_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_CODE_11 = 10'b1010101011;

    // Lane 1 gets the inverted band; every other lane uses the blue/red one.
    localparam logic [9:0] GUARD_BAND_0 = 10'b1011001100;
    localparam logic [9:0] GUARD_BAND_1 = 10'b0100110011;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    function automatic logic [8:0] tmds_qm(input logic [7:0] d);
        logic [3:0] ones;
        logic       use_xnor;
        logic [8:0] q;
        ones     = popcount8(d);
        use_xnor = (ones > 4'd4) || ((ones == 4'd4) && !d[0]);
        q        = '0;
        q[0]     = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        q[8] = ~use_xnor;
        return q;
    endfunction

    function automatic logic [9:0] terc4_code(input logic [3:0] nib);
        logic [9:0] c;
        case (nib)
            4'h0: c = 10'b1010011100;
            4'h1: c = 10'b1001100011;
            4'h2: c = 10'b1011100100;
            4'h3: c = 10'b1011100010;
            4'h4: c = 10'b0101110001;
            4'h5: c = 10'b0100011110;
            4'h6: c = 10'b0110001110;
            4'h7: c = 10'b0100111100;
            4'h8: c = 10'b1011001100;
            4'h9: c = 10'b0100111001;
            4'hA: c = 10'b0110011100;
            4'hB: c = 10'b1011000110;
            4'hC: c = 10'b1010001110;
            4'hD: c = 10'b1001110001;
            4'hE: c = 10'b0101100011;
            default: c = 10'b1011000011;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/tmds_lane_enc.sv
// rtl/tmds_lane_enc.sv - one TMDS lane: q_m stage, symbol stage, running disparity
import tmds_pkg::*;

module tmds_lane_enc #(
    parameter int LANE_IDX = 0
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic [1:0] mode_in,
    input  logic [7:0] data_in,
    input  logic [1:0] ctrl_in,
    input  logic [3:0] terc_in,
    output logic [9:0] tmds_out,
    output logic [4:0] disp_out
);

    logic [8:0]        qm_q;
    tmds_mode_t        mode_q;
    logic [1:0]        ctrl_q;
    logic [3:0]        terc_q;
    logic [9:0]        sym_q, sym_d;
    logic signed [4:0] cnt_q, cnt_d;
    logic signed [4:0] n1, n0;
    logic              q8;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            qm_q   <= '0;
            mode_q <= MODE_CONTROL;
            ctrl_q <= '0;
            terc_q <= '0;
            sym_q  <= '0;
            cnt_q  <= '0;
        end else begin
            qm_q   <= tmds_qm(data_in);
            mode_q <= tmds_mode_t'(mode_in);
            ctrl_q <= ctrl_in;
            terc_q <= terc_in;
            sym_q  <= sym_d;
            cnt_q  <= cnt_d;
        end
    end

    assign q8 = qm_q[8];
    assign n1 = signed'({1'b0, popcount8(qm_q[7:0])});
    assign n0 = 5'sd8 - n1;

    always_comb begin
        sym_d = '0;
        cnt_d = '0;
        case (mode_q)
            MODE_VIDEO: begin
                if ((cnt_q == 5'sd0) || (n1 == n0)) begin
                    sym_d = {~q8, q8, q8 ? qm_q[7:0] : ~qm_q[7:0]};
                    cnt_d = q8 ? (cnt_q + (n1 - n0)) : (cnt_q + (n0 - n1));
                end else if (((cnt_q > 5'sd0) && (n1 > n0)) ||
                             ((cnt_q < 5'sd0) && (n0 > n1))) begin
                    sym_d = {1'b1, q8, ~qm_q[7:0]};
                    cnt_d = cnt_q + (q8 ? 5'sd2 : 5'sd0) + (n0 - n1);
                end else begin
                    sym_d = {1'b0, q8, qm_q[7:0]};
                    cnt_d = cnt_q - (q8 ? 5'sd0 : 5'sd2) + (n1 - n0);
                end
            end
            MODE_GUARD: sym_d = (LANE_IDX == 1) ? GUARD_BAND_1 : GUARD_BAND_0;
            MODE_TERC4: sym_d = terc4_code(terc_q);
            default: begin
                case (ctrl_q)
                    2'b00:   sym_d = CTRL_CODE_00;
                    2'b01:   sym_d = CTRL_CODE_01;
                    2'b10:   sym_d = CTRL_CODE_10;
                    default: sym_d = CTRL_CODE_11;
                endcase
            end
        endcase
    end

    assign tmds_out = sym_q;
    assign disp_out = cnt_q;

endmodule

// File: rtl/tmds_encoder_multi.sv
// rtl/tmds_encoder_multi.sv - NUM_CH lock-step TMDS lanes with shared mode
import tmds_pkg::*;

module tmds_encoder_multi #(
    parameter int NUM_CH = 3
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic [1:0]            mode_in,
    input  logic [8*NUM_CH-1:0]   data_in,
    input  logic [2*NUM_CH-1:0]   ctrl_in,
    input  logic [4*NUM_CH-1:0]   terc_in,
    output logic [10*NUM_CH-1:0]  tmds_out,
    output logic [5*NUM_CH-1:0]   disp_out
);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        tmds_lane_enc #(
            .LANE_IDX (k)
        ) u_lane (
            .clk_in   (clk_in),
            .rst_n_in (rst_n_in),
            .mode_in  (mode_in),
            .data_in  (data_in[8*k +: 8]),
            .ctrl_in  (ctrl_in[2*k +: 2]),
            .terc_in  (terc_in[4*k +: 4]),
            .tmds_out (tmds_out[10*k +: 10]),
            .disp_out (disp_out[5*k +: 5])
        );
    end

endmodule

// File: tb/tb_tmds_encoder_multi.sv
// tb/tb_tmds_encoder_multi.sv - randomized bench against a behavioural TMDS model
module tb_tmds_encoder_multi;

    localparam int NC = 3;

    localparam logic [9:0] CTRL_TAB [4] = '{10'b1101010100, 10'b0010101011,
                                            10'b0101010100, 10'b1010101011};
    localparam logic [9:0] TERC_TAB [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};
    localparam logic [9:0] GB_BR = 10'b1011001100;
    localparam logic [9:0] GB_G  = 10'b0100110011;

    typedef struct {
        logic [1:0]      mode;
        logic [8*NC-1:0] data;
        logic [2*NC-1:0] ctrl;
        logic [4*NC-1:0] terc;
    } stim_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic [1:0]         mode = '0;
    logic [8*NC-1:0]    data = '0;
    logic [2*NC-1:0]    ctrl = '0;
    logic [4*NC-1:0]    terc = '0;
    logic [10*NC-1:0]   tmds;
    logic [5*NC-1:0]    disp;

    int n_cmp = 0;
    int n_err = 0;

    stim_t           pipe[$];
    int              m_cnt [NC];
    logic [10*NC-1:0] exp_tmds;
    logic [5*NC-1:0]  exp_disp;

    always #5 clk = ~clk;

    tmds_encoder_multi #(.NUM_CH(NC)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .mode_in  (mode),
        .data_in  (data),
        .ctrl_in  (ctrl),
        .terc_in  (terc),
        .tmds_out (tmds),
        .disp_out (disp)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic stim_t mk(input logic [1:0] m, input logic [8*NC-1:0] d,
                                 input logic [2*NC-1:0] c, input logic [4*NC-1:0] t);
        stim_t s;
        s.mode = m; s.data = d; s.ctrl = c; s.terc = t;
        return s;
    endfunction

    // Bit i of q_m is the parity of d[i:0], inverted on odd bits when XNOR chaining.
    task automatic model_encode(input stim_t s);
        for (int k = 0; k < NC; k++) begin
            logic [7:0] d, q, mask;
            logic [9:0] out;
            int ones, n1, n0, q8;
            bit xn;
            d    = s.data[8*k +: 8];
            ones = $countones(d);
            xn   = (ones > 4) || (ones == 4 && d[0] == 1'b0);
            for (int i = 0; i < 8; i++) begin
                mask = 8'hFF >> (7 - i);
                q[i] = (^(d & mask)) ^ (xn && (i % 2 == 1));
            end
            q8 = xn ? 0 : 1;
            n1 = $countones(q);
            n0 = 8 - n1;
            case (s.mode)
                2'd1: begin
                    if (m_cnt[k] == 0 || n1 == n0) begin
                        if (q8 == 1) begin out = {2'b01, q};  m_cnt[k] += n1 - n0; end
                        else         begin out = {2'b10, ~q}; m_cnt[k] += n0 - n1; end
                    end else if ((m_cnt[k] > 0 && n1 > n0) || (m_cnt[k] < 0 && n0 > n1)) begin
                        out = {1'b1, q8[0], ~q};
                        m_cnt[k] += 2 * q8 + n0 - n1;
                    end else begin
                        out = {1'b0, q8[0], q};
                        m_cnt[k] += -2 * (1 - q8) + n1 - n0;
                    end
                end
                2'd2: begin out = (k == 1) ? GB_G : GB_BR; m_cnt[k] = 0; end
                2'd3: begin out = TERC_TAB[s.terc[4*k +: 4]]; m_cnt[k] = 0; end
                default: begin out = CTRL_TAB[s.ctrl[2*k +: 2]]; m_cnt[k] = 0; end
            endcase
            exp_tmds[10*k +: 10] = out;
            exp_disp[5*k +: 5]   = 5'(m_cnt[k]);
        end
    endtask

    task automatic reset_model();
        for (int k = 0; k < NC; k++) m_cnt[k] = 0;
        pipe.delete();
        pipe.push_back(mk(2'd0, '0, '0, '0));
    endtask

    task automatic step(input stim_t s);
        mode = s.mode; data = s.data; ctrl = s.ctrl; terc = s.terc;
        @(posedge clk);
        #1;
        pipe.push_back(s);
        model_encode(pipe.pop_front());
        check("tmds", 64'(tmds), 64'(exp_tmds));
        check("disp", 64'(disp), 64'(exp_disp));
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_tmds_now", 64'(tmds), 64'd0);
        check("rst_disp_now", 64'(disp), 64'd0);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("rst_tmds_hold", 64'(tmds), 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        reset_model();
    endtask

    initial begin
        stim_t c0, v0, g, t;
        c0 = mk(2'd0, '0, '0, '0);
        v0 = mk(2'd1, 24'h00FF00, '0, '0);
        g  = mk(2'd2, '0, '0, '0);
        t  = mk(2'd3, '0, '0, 12'hF50);

        async_reset();
        step(mk(2'd0, '0, 6'b111100, '0));
        step(c0);
        check("ctrl00_lane0", 64'(tmds[9:0]), 64'(10'b1101010100));

        step(v0);
        step(v0);
        check("v00_sym0", 64'(tmds[9:0]), 64'(10'b0100000000));
        check("v00_disp0", 64'(disp[4:0]), 64'(5'h18));
        check("vff_sym1", 64'(tmds[19:10]), 64'(10'b1000000000));
        check("vff_disp1", 64'(disp[9:5]), 64'(5'h18));
        step(v0);
        check("v00_sym1", 64'(tmds[9:0]), 64'(10'b1111111111));
        check("v00_disp1", 64'(disp[4:0]), 64'(5'h02));
        step(c0);
        check("v00_sym2", 64'(tmds[9:0]), 64'(10'b0100000000));
        check("v00_disp2", 64'(disp[4:0]), 64'(5'h1A));
        step(c0);

        step(g);
        step(c0);
        check("guard_sym", 64'(tmds), 64'({GB_BR, GB_G, GB_BR}));
        check("guard_disp", 64'(disp), 64'd0);

        step(t);
        step(c0);
        check("terc_lane0", 64'(tmds[9:0]), 64'(10'b1010011100));
        check("terc_lane2", 64'(tmds[29:20]), 64'(10'b1011000011));

        for (int i = 0; i < 6; i++) step((i % 2 == 0) ? mk(2'd1, '0, '0, '0) : c0);
        step(mk(2'd1, '0, '0, '0));
        step(mk(2'd1, '0, '0, '0));
        async_reset();
        step(mk(2'd1, '0, '0, '0));
        step(mk(2'd1, '0, '0, '0));
        check("post_rst_disp0", 64'(disp[4:0]), 64'(5'h18));

        for (int i = 0; i < 600; i++) begin
            stim_t s;
            int r;
            r = $urandom_range(0, 9);
            s.mode = (r < 6) ? 2'd1 : 2'(r - 6);
            for (int k = 0; k < NC; k++) begin
                case ($urandom_range(0, 7))
                    0: s.data[8*k +: 8] = 8'h00;
                    1: s.data[8*k +: 8] = 8'hFF;
                    2: s.data[8*k +: 8] = 8'h0F;
                    3: s.data[8*k +: 8] = 8'h1E;
                    default: s.data[8*k +: 8] = 8'($urandom);
                endcase
            end
            s.ctrl = (2*NC)'($urandom);
            s.terc = (4*NC)'($urandom);
            step(s);
            if ($urandom_range(0, 149) == 0) async_reset();
        end

        step(c0);
        step(c0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tmds_encoder_multi.md
Name: tmds_encoder_multi

Overview:
- Parametrised multi-channel TMDS/HDMI encoder; successor to the single-channel video/control encoder.
- Encodes NUM_CH lanes in lock-step with a 2-stage pipeline, a correct signed running disparity per lane, and four modes: control, video, video guard band, and TERC4 data island.
- Sits between the video/data-island timing generator and the 10:1 serialisers.

Parameters:
NUM_CH, 3, number of TMDS lanes (lane 0 = blue, 1 = green, 2 = red); legal range 1..4.

Ports:
clk_in  input  1  pixel clock
rst_n_in  input  1  reset, asynchronous, active-low
mode_in  input  2  0 = CONTROL, 1 = VIDEO, 2 = VIDEO_GUARD, 3 = TERC4
data_in  input  8*NUM_CH  video byte per lane, lane k at [8k+7:8k]
ctrl_in  input  2*NUM_CH  control bits per lane {c1,c0}; lane 0 carries {vs,hs}
terc_in  input  4*NUM_CH  TERC4 nibble per lane
tmds_out  output  10*NUM_CH  10-bit symbol per lane, lane k at [10k+9:10k]
disp_out  output  5*NUM_CH  signed running disparity per lane (debug)

Behaviour:
- Reset is asynchronous. Assertion immediately clears all pipeline registers, tmds_out, and disparity to 0, including mid-frame. Stage-1 mode resets to CONTROL. After deassertion, the first valid symbol appears 2 clocks after the first sampled input.
- Latency is exactly 2 cycles for every mode, and all lanes are aligned. Input is accepted every cycle, with no handshake.
- Stage 1 (registered), per lane:
  - Compute q_m[8:0] from data_in.
  - If N1(d) > 4, or N1(d) == 4 and d[0] == 0: use XNOR chaining, q_m[8] = 0.
  - Otherwise: use XOR chaining, q_m[8] = 1.
  - q_m[0] = d[0].
  - Register mode, ctrl, and terc alongside q_m.
- Stage 2, VIDEO mode, with cnt as a 5-bit signed disparity and N1/N0 counted over q_m[7:0]:
  - If cnt == 0 or N1 == N0: out = {~q_m8, q_m8, q_m8 ? q_m[7:0] : ~q_m[7:0]}; cnt += q_m8 ? (N1 - N0) : (N0 - N1).
  - Else if (cnt > 0 and N1 > N0) or (cnt < 0 and N0 > N1): out = {1, q_m8, ~q_m[7:0]}; cnt += 2*q_m8 + (N0 - N1).
  - Else: out = {0, q_m8, q_m[7:0]}; cnt += -2*(~q_m8) + (N1 - N0).
  - All arithmetic is signed two's complement. N1/N0 are extended to 5 bits signed before subtraction. The tested range never wraps.
- CONTROL mode: emit 00 → 1101010100, 01 → 0010101011, 10 → 0101010100, 11 → 1010101011. cnt is cleared to 0.
- VIDEO_GUARD mode: lanes 0 and 2 emit 1011001100; lane 1 emits 0100110011. Lane 3 (if present) emits 1011001100. cnt is cleared to 0.
- TERC4 mode: emit the HDMI 1.4 TERC4 code for the nibble (e.g. 0000 → 1010011100, 1111 → 1011000011). cnt is cleared to 0.
- Mode switch: the stage-2 mode is the registered stage-1 mode. Any non-VIDEO symbol clears cnt, so the first VIDEO symbol after it starts from cnt = 0.
- disp_out is the post-update cnt register, aligned with tmds_out.
- A mode_in value is never illegal (2-bit, fully decoded).

Decomposition:
- Package tmds_pkg:
  - mode enum (tmds_mode_t)
  - 4 control-code constants
  - guard-band constants
  - 16-entry TERC4 lookup function
  - qm function
- Sub-module tmds_lane_enc: one lane, both pipeline stages plus the disparity register.
- Top: generate loop instantiating NUM_CH copies and slicing the buses.

Test Plan:
- Reset then CONTROL: rst_n_in = 0 → tmds_out = 0 and disp_out = 0 immediately (no clock edge). Release, drive mode 0 with lane0 ctrl = 00 → lane0 = 1101010100 two clocks later.
- VIDEO, lane0 data 0x00 for 3 cycles from cnt = 0 → lane0 outputs 0100000000, 1111111111, 0100000000; disp_out = -8, +2, -6.
- VIDEO, lane1 data 0xFF from cnt = 0 → q_m = 0_11111111, lane1 = 1000000000, disp = -8.
- VIDEO_GUARD → lanes 0, 1, 2 = 1011001100, 0100110011, 1011001100; all disp_out = 0.
- TERC4, nibbles 0000 / 1111 on lanes 0 / 2 → 1010011100 / 1011000011.
- Switch VIDEO → CONTROL → VIDEO every cycle with 0x00, plus async reset asserted mid-VIDEO burst → mode/output alignment holds at exactly 2-cycle latency; disparity restarts from 0; outputs read 0 during reset.
